// File: rtl/chan_sh_pkg.sv
// Shared types for the multi-channel sample/hold stage: lane FSM states and the
// stale-output policy.
package chan_sh_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HOLD  = 2'd2,
        STALE = 2'd3
    } sh_state_t;

    typedef enum logic {
        HOLD_LAST  = 1'b0,
        ZERO_STALE = 1'b1
    } sh_mode_t;

    // Width needed to count hold cycles from 0 up to and including hold_max.
    function automatic int hold_cnt_w(input int hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/chan_sh_lane.sv
// One sample/hold lane: captures data while selected, holds it afterwards and
// marks it stale after HOLD_MAX unselected cycles.
module chan_sh_lane
    import chan_sh_pkg::*;
#(
    parameter int W        = 8,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  sh_mode_t         i_mode,
    input  logic             i_clr,
    input  logic             i_sel,
    input  logic [W-1:0]     i_d,
    output logic [W-1:0]     o_y,
    output logic             o_y_vld,
    output logic             o_stale,
    output logic [CNT_W-1:0] o_upd_cnt,
    output sh_state_t        o_state
);

    localparam int              HW       = hold_cnt_w(HOLD_MAX);
    localparam logic [HW-1:0]   HOLD_LIM = HW'(HOLD_MAX);

    sh_state_t          r_state;
    sh_state_t          w_state_nxt;
    logic [W-1:0]       r_y;
    logic [W-1:0]       w_y_nxt;
    logic [CNT_W-1:0]   r_upd_cnt;
    logic [CNT_W-1:0]   w_upd_cnt_nxt;
    logic [CNT_W-1:0]   w_upd_cnt_inc;
    logic [HW-1:0]      r_hold_cnt;
    logic [HW-1:0]      w_hold_cnt_nxt;

    assign w_upd_cnt_inc = (&r_upd_cnt) ? r_upd_cnt : r_upd_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt    = r_state;
        w_y_nxt        = r_y;
        w_upd_cnt_nxt  = r_upd_cnt;
        w_hold_cnt_nxt = r_hold_cnt;

        if (i_clr) begin
            w_state_nxt    = IDLE;
            w_y_nxt        = '0;
            w_upd_cnt_nxt  = '0;
            w_hold_cnt_nxt = '0;
        end else if (i_sel) begin
            // Capture looks the same from every state, including leaving STALE.
            w_state_nxt    = TRACK;
            w_y_nxt        = i_d;
            w_upd_cnt_nxt  = w_upd_cnt_inc;
            w_hold_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    w_state_nxt = IDLE;
                end
                TRACK, HOLD: begin
                    w_state_nxt    = HOLD;
                    w_hold_cnt_nxt = (r_state == TRACK) ? HW'(1) : r_hold_cnt + HW'(1);
                    if (w_hold_cnt_nxt == HOLD_LIM) begin
                        w_state_nxt = STALE;
                        if (i_mode == ZERO_STALE) begin
                            w_y_nxt = '0;
                        end
                    end
                end
                STALE: begin
                    if (i_mode == ZERO_STALE) begin
                        w_y_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_y        <= '0;
            r_upd_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_y        <= w_y_nxt;
            r_upd_cnt  <= w_upd_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Flags are decoded from registered state only, so no input reaches them combinationally.
    assign o_y       = r_y;
    assign o_y_vld   = (r_state == TRACK) || (r_state == HOLD);
    assign o_stale   = (r_state == STALE);
    assign o_upd_cnt = r_upd_cnt;
    assign o_state   = r_state;

endmodule

// File: rtl/chan_sample_hold.sv
// N independent sample/hold lanes with packed buses; lane FSM states are packed
// onto o_dbg_state (2 bits per lane, lane 0 in the low bits).
module chan_sample_hold
    import chan_sh_pkg::*;
#(
    parameter int W        = 8,
    parameter int N        = 4,
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               mode,
    input  logic               clr,
    input  logic [N-1:0]       sel,
    input  logic [N*W-1:0]     d,
    output logic [N*W-1:0]     y,
    output logic [N-1:0]       y_vld,
    output logic [N-1:0]       stale,
    output logic [N*CNT_W-1:0] upd_cnt,
    output logic [2*N-1:0]     o_dbg_state
);

    sh_mode_t  w_mode;
    sh_state_t w_state [N];

    assign w_mode = sh_mode_t'(mode);

    for (genvar g = 0; g < N; g++) begin : g_lane
        chan_sh_lane #(
            .W        (W),
            .HOLD_MAX (HOLD_MAX),
            .CNT_W    (CNT_W)
        ) u_lane (
            .clk       (clk),
            .rstn      (rstn),
            .i_mode    (w_mode),
            .i_clr     (clr),
            .i_sel     (sel[g]),
            .i_d       (d[g*W +: W]),
            .o_y       (y[g*W +: W]),
            .o_y_vld   (y_vld[g]),
            .o_stale   (stale[g]),
            .o_upd_cnt (upd_cnt[g*CNT_W +: CNT_W]),
            .o_state   (w_state[g])
        );

        assign o_dbg_state[g*2 +: 2] = w_state[g];
    end

endmodule
